fifo_ctrl: RTL and testbench

- Pointer and flag controller for a circular-buffer FIFO. It sits directly upstream of the team's synchronous-write / asynchronous-read register file, 2**W entries of B bits.
- It turns producer/consumer strobes into the register file's wr_en, w_addr and r_addr, and reports full, empty and error status.
- Data never passes through this block. The producer drives w_data straight to the register file, and the consumer reads r_data from it.

---
 rtl/fifo_ctrl.sv | 84 ++++++++
 tb/tb_fifo_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for a 2**W-entry circular-buffer FIFO
// that sits in front of a synchronous-write / asynchronous-read register file.
// No data passes through this block. It only produces wr_en, w_addr and r_addr,
// and it reports full, empty and the overflow/underflow status pulses.
// Optional feature macro: FIFO_CTRL_LEVEL_EN adds an occupancy counter on level.
// When the macro is undefined, level is tied to 0.
module fifo_ctrl #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr,
  input  logic         rd,
  output logic         wr_en,
  output logic [W-1:0] w_addr,
  output logic [W-1:0] r_addr,
  output logic         full,
  output logic         empty,
  output logic         wr_err,
  output logic         rd_err,
  output logic [W:0]   level
);

  localparam logic [W-1:0] PTR_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] w_ptr, r_ptr;
  logic [W-1:0] w_nxt, r_nxt;
  logic         push, pop;

  // A push is accepted when the FIFO has room. It is also accepted when a
  // concurrent pop frees the slot being written. A pop needs data present.
  assign push   = wr & (~full | rd);
  assign pop    = rd & ~empty;
  assign wr_en  = push;
  assign w_nxt  = w_ptr + PTR_ONE;
  assign r_nxt  = r_ptr + PTR_ONE;
  assign w_addr = w_ptr;
  assign r_addr = r_ptr;

  // Pointer, flag and error-pulse state. Pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_ptr  <= '0;
      r_ptr  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      wr_err <= wr & ~push;
      rd_err <= rd & ~pop;
      if (push) w_ptr <= w_nxt;
      if (pop)  r_ptr <= r_nxt;
      if (push & ~pop) begin
        empty <= 1'b0;
        full  <= (w_nxt == r_ptr);
      end else if (pop & ~push) begin
        full  <= 1'b0;
        empty <= (r_nxt == w_ptr);
      end
    end
  end

`ifdef FIFO_CTRL_LEVEL_EN
  localparam logic [W:0] LVL_ONE = {{W{1'b0}}, 1'b1};
  logic [W:0] lvl;

  // Occupancy tracks net accepted pushes minus accepted pops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lvl <= '0;
    end else if (push & ~pop) begin
      lvl <= lvl + LVL_ONE;
    end else if (pop & ~push) begin
      lvl <= lvl - LVL_ONE;
    end
  end

  assign level = lvl;
`else
  assign level = '0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed and random stimulus for fifo_ctrl (W=2). The expected
// values come from a queue-based FIFO model. A small register file in the bench
// checks that data comes back in push order.
module tb_fifo_ctrl;
  localparam int W = 2;
  localparam int DEPTH = 1 << W;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         wr, rd;
  logic         wr_en;
  logic [W-1:0] w_addr, r_addr;
  logic         full, empty, wr_err, rd_err;
  logic [W:0]   level;

  logic [7:0]   w_data;
  logic [7:0]   mem [DEPTH];
  logic [7:0]   r_data;

  // Reference model state
  logic [7:0]   q[$];
  int           m_wp, m_rp;
  bit           m_werr, m_rerr;

  int vectors = 0;
  int miscompares = 0;

  fifo_ctrl #(.W(W)) dut (
    .clk(clk), .reset_n(reset_n), .wr(wr), .rd(rd), .wr_en(wr_en),
    .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
    .wr_err(wr_err), .rd_err(rd_err), .level(level)
  );

  always #5 clk = ~clk;

  // External register file: synchronous write, asynchronous read
  always_ff @(posedge clk) if (wr_en) mem[w_addr] <= w_data;
  assign r_data = mem[r_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wp = 0; m_rp = 0; m_werr = 0; m_rerr = 0;
  endtask

  task automatic check_outs(input string tag);
    int exp_lvl;
`ifdef FIFO_CTRL_LEVEL_EN
    exp_lvl = q.size();
`else
    exp_lvl = 0;
`endif
    check({tag, ".w_addr"}, 32'(w_addr), 32'(m_wp));
    check({tag, ".r_addr"}, 32'(r_addr), 32'(m_rp));
    check({tag, ".full"},   32'(full),   32'(q.size() == DEPTH));
    check({tag, ".empty"},  32'(empty),  32'(q.size() == 0));
    check({tag, ".wr_err"}, 32'(wr_err), 32'(m_werr));
    check({tag, ".rd_err"}, 32'(rd_err), 32'(m_rerr));
    check({tag, ".level"},  32'(level),  32'(exp_lvl));
  endtask

  // One functional cycle, entered and left at a falling edge
  task automatic step(input string tag, input logic w, input logic r);
    bit acc_push, acc_pop;
    logic [7:0] d;
    wr = w; rd = r; w_data = 8'($urandom);
    #1;
    acc_push = w && (q.size() < DEPTH || r);
    acc_pop  = r && (q.size() > 0);
    check({tag, ".wr_en"}, 32'(wr_en), 32'(acc_push));
    if (q.size() > 0) check({tag, ".r_data"}, 32'(r_data), 32'(q[0]));
    d = w_data;
    @(posedge clk);
    if (acc_pop)  begin void'(q.pop_front()); m_rp = (m_rp + 1) % DEPTH; end
    if (acc_push) begin q.push_back(d);       m_wp = (m_wp + 1) % DEPTH; end
    m_werr = w && !acc_push;
    m_rerr = r && !acc_pop;
    @(negedge clk);
    check_outs(tag);
  endtask

  task automatic do_reset(input string tag, input logic w, input logic r, input int n);
    reset_n = 1'b0; wr = w; rd = r; w_data = 8'($urandom);
    repeat (n) @(posedge clk);
    model_reset();
    @(negedge clk);
    check_outs(tag);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; wr = 1'b1; rd = 1'b1; w_data = '0;
    model_reset();
    @(negedge clk);
    do_reset("reset", 1'b1, 1'b1, 2);

    // Fill, then overflow, then one idle cycle to see wr_err drop
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0);
    step("overflow", 1'b1, 1'b0);
    step("idle_after_ovf", 1'b0, 1'b0);

    // Drain, then underflow, then idle
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1);
    step("underflow", 1'b0, 1'b1);
    step("idle_after_udf", 1'b0, 1'b0);

    // Simultaneous push and pop on an empty FIFO: only the push is accepted
    step("both_empty", 1'b1, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) step("refill", 1'b1, 1'b0);
    // Simultaneous push and pop on a full FIFO: both are accepted
    step("both_full", 1'b1, 1'b1);
    step("both_full2", 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 1'b1);

    // Wrap-around: push 3, pop 3, push 4, then read back in order
    do_reset("reset_wrap", 1'b0, 1'b0, 1);
    for (int i = 0; i < 3; i++) step("wrap_push3", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("wrap_pop3", 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("wrap_push4", 1'b1, 1'b0);
    check("wrap_full_ptr", 32'(w_addr == 2'd3 && r_addr == 2'd3 && full), 32'd1);
    for (int i = 0; i < DEPTH; i++) step("wrap_pop4", 1'b0, 1'b1);

    // Reset during operation while a write is requested
    step("mid_push", 1'b1, 1'b0);
    step("mid_push", 1'b1, 1'b0);
    do_reset("reset_mid", 1'b1, 1'b0, 1);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0)
        do_reset("rand_reset", 1'($urandom), 1'($urandom), 1);
      else
        step("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog in case the clock or the stimulus stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
